i2c_slave_regfile: RTL and testbench

- Downstream consumer of the I2C byte receiver: takes each received byte plus its ack-phase strobe and decides ACK/NACK.
- Decodes slave address, register pointer and data bytes, and writes a small register bank.
- Also supplies read data and a read request to the I2C transmit path, and gives the local logic a host read/write port onto the same registers.

---
 rtl/i2c_pkg.sv | 19 +
 rtl/i2c_regbank.sv | 35 +++
 rtl/i2c_slave_regfile.sv | 127 ++++++++++++
 tb/tb_i2c_slave_regfile.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and constants for the I2C slave register file
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_PTR,
    ST_WRITE,
    ST_READ,
    ST_IGNORE
  } slave_state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_regbank.sv
// rtl/i2c_regbank.sv - NUM_REGS x 8 register array, two read ports, async clear
module i2c_regbank #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_i2c_we,
  input  logic [ADDR_W-1:0] i_i2c_waddr,
  input  logic [7:0]        i_i2c_wdata,
  input  logic              i_host_we,
  input  logic [ADDR_W-1:0] i_host_waddr,
  input  logic [7:0]        i_host_wdata,
  input  logic [ADDR_W-1:0] i_raddr_a,
  output logic [7:0]        o_rdata_a,
  input  logic [ADDR_W-1:0] i_raddr_b,
  output logic [7:0]        o_rdata_b
);

  logic [7:0] r_mem [NUM_REGS];

  // Host enable arrives already masked on collisions; I2C is written last regardless.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= 8'h00;
    end else begin
      if (i_host_we) r_mem[i_host_waddr] <= i_host_wdata;
      if (i_i2c_we)  r_mem[i_i2c_waddr]  <= i_i2c_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/i2c_slave_regfile.sv
// rtl/i2c_slave_regfile.sv - I2C slave byte decoder with ACK control and register bank
module i2c_slave_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h42,
  parameter int         NUM_REGS   = 16,
  parameter int         ADDR_W     = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              stop,
  input  logic [7:0]        rx_data,
  input  logic              data_rdy,
  output logic              ack,
  output logic              rd_req,
  output logic [7:0]        rd_data,
  input  logic              tx_done,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic              host_we,
  input  logic [7:0]        host_wdata,
  output logic [7:0]        host_rdata
);

  slave_state_t      r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_ack;
  logic              r_rd_req;
  logic              r_wr_strobe;
  logic [ADDR_W-1:0] r_wr_addr;
  logic              r_data_rdy_q;

  logic w_event;
  logic w_i2c_we;
  logic w_host_we;

  assign w_event   = r_data_rdy_q & ~data_rdy;
  // A byte coinciding with start/stop is dropped, so it must not reach the bank.
  assign w_i2c_we  = w_event & ~start & ~stop & (r_state == ST_WRITE);
  assign w_host_we = host_we & ~(w_i2c_we & (host_addr == r_ptr));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= ST_IDLE;
      r_ptr        <= '0;
      r_ack        <= I2C_NACK;
      r_rd_req     <= 1'b0;
      r_wr_strobe  <= 1'b0;
      r_wr_addr    <= '0;
      r_data_rdy_q <= 1'b1;
    end else begin
      r_data_rdy_q <= data_rdy;
      r_wr_strobe  <= 1'b0;
      if (stop) begin
        r_state  <= ST_IDLE;
        r_ack    <= I2C_NACK;
        r_rd_req <= 1'b0;
      end else if (start) begin
        r_state  <= ST_ADDR;
        r_ack    <= I2C_NACK;
        r_rd_req <= 1'b0;
      end else if (w_event) begin
        case (r_state)
          ST_ADDR: begin
            if (rx_data[7:1] == SLAVE_ADDR) begin
              r_ack <= I2C_ACK;
              if (rx_data[0] == RW_WRITE) begin
                r_state <= ST_PTR;
              end else begin
                r_state  <= ST_READ;
                r_rd_req <= 1'b1;
              end
            end else begin
              r_ack   <= I2C_NACK;
              r_state <= ST_IGNORE;
            end
          end
          ST_PTR: begin
            if ({24'd0, rx_data} < 32'(NUM_REGS)) begin
              r_ptr   <= rx_data[ADDR_W-1:0];
              r_ack   <= I2C_ACK;
              r_state <= ST_WRITE;
            end else begin
              r_ack   <= I2C_NACK;
              r_state <= ST_IGNORE;
            end
          end
          ST_WRITE: begin
            r_wr_strobe <= 1'b1;
            r_wr_addr   <= r_ptr;
            r_ack       <= I2C_ACK;
            r_ptr       <= r_ptr + 1'b1;
          end
          default: r_ack <= I2C_NACK;
        endcase
      end else if (tx_done && r_state == ST_READ) begin
        r_ptr <= r_ptr + 1'b1;
      end
    end
  end

  i2c_regbank #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_regbank (
    .clk          (clk),
    .rstn         (rstn),
    .i_i2c_we     (w_i2c_we),
    .i_i2c_waddr  (r_ptr),
    .i_i2c_wdata  (rx_data),
    .i_host_we    (w_host_we),
    .i_host_waddr (host_addr),
    .i_host_wdata (host_wdata),
    .i_raddr_a    (r_ptr),
    .o_rdata_a    (rd_data),
    .i_raddr_b    (host_addr),
    .o_rdata_b    (host_rdata)
  );

  assign ack       = r_ack;
  assign rd_req    = r_rd_req;
  assign wr_strobe = r_wr_strobe;
  assign wr_addr   = r_wr_addr;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// tb/tb_i2c_slave_regfile.sv - self-checking bench for i2c_slave_regfile
module tb_i2c_slave_regfile;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start, stop, data_rdy, tx_done, host_we;
  logic [7:0] rx_data, host_wdata;
  logic [3:0] host_addr;
  logic       ack, rd_req, wr_strobe;
  logic [7:0] rd_data, host_rdata;
  logic [3:0] wr_addr;

  int total = 0;
  int bad   = 0;
  int strobe_cnt = 0;
  logic [3:0] exp_q [$];
  logic [7:0] mem [16];

  always #5 clk = ~clk;

  i2c_slave_regfile #(.SLAVE_ADDR(7'h42), .NUM_REGS(16), .ADDR_W(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .stop       (stop),
    .rx_data    (rx_data),
    .data_rdy   (data_rdy),
    .ack        (ack),
    .rd_req     (rd_req),
    .rd_data    (rd_data),
    .tx_done    (tx_done),
    .wr_strobe  (wr_strobe),
    .wr_addr    (wr_addr),
    .host_addr  (host_addr),
    .host_we    (host_we),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata)
  );

  // Every write strobe must match the next expected register index.
  always @(negedge clk) begin
    if (rstn === 1'b1 && wr_strobe === 1'b1) begin
      strobe_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_strobe wr_addr got=%0d exp=none", wr_addr);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (wr_addr !== e) begin
          bad++;
          $display("FAIL strobe_addr got=%0d exp=%0d", wr_addr, e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic pulse(input int which);
    @(posedge clk); #1;
    if (which == 0) start = 1'b1; else if (which == 1) stop = 1'b1; else tx_done = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0; tx_done = 1'b0;
  endtask

  task automatic send_byte_host(input logic [7:0] d, input logic exp_ack, input string nm,
                                input logic hwe, input logic [3:0] ha, input logic [7:0] hd);
    @(posedge clk); #1;
    rx_data = d; data_rdy = 1'b0; host_we = hwe; host_addr = ha; host_wdata = hd;
    @(posedge clk); #1;
    host_we = 1'b0;
    total++;
    if (ack !== exp_ack) begin
      bad++;
      $display("FAIL %s ack got=%0b exp=%0b", nm, ack, exp_ack);
    end
    repeat (2) @(posedge clk);
    #1 data_rdy = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic exp_ack, input string nm);
    send_byte_host(d, exp_ack, nm, 1'b0, 4'd0, 8'h00);
  endtask

  task automatic check_reg(input logic [3:0] a, input logic [7:0] e, input string nm);
    host_addr = a;
    #1;
    total++;
    if (host_rdata !== e) begin
      bad++;
      $display("FAIL %s reg[%0d] got=%02h exp=%02h", nm, a, host_rdata, e);
    end
  endtask

  task automatic check_bit(input logic got, input logic e, input string nm);
    total++;
    if (got !== e) begin
      bad++;
      $display("FAIL %s got=%0b exp=%0b", nm, got, e);
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0; start = 0; stop = 0; tx_done = 0; host_we = 0;
    rx_data = 8'h00; data_rdy = 1'b1; host_addr = 4'd0; host_wdata = 8'h00;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;
    check_bit(ack, 1'b1, "reset_ack");
    check_bit(rd_req, 1'b0, "reset_rd_req");
    check_bit(wr_strobe, 1'b0, "reset_wr_strobe");
    total++;
    if (wr_addr !== 4'd0) begin
      bad++;
      $display("FAIL reset_wr_addr got=%0d exp=0", wr_addr);
    end
    check_reg(4'd0, 8'h00, "reset_reg");
    check_reg(4'd9, 8'h00, "reset_reg");
  endtask

  task automatic test_write;
    int s0;
    s0 = strobe_cnt;
    pulse(0);
    send_byte(8'h84, 1'b0, "wr_addr_byte");
    send_byte(8'h03, 1'b0, "wr_ptr_byte");
    exp_q.push_back(4'd3); mem[3] = 8'hA5;
    send_byte(8'hA5, 1'b0, "wr_data0");
    exp_q.push_back(4'd4); mem[4] = 8'h5A;
    send_byte(8'h5A, 1'b0, "wr_data1");
    pulse(1);
    check_bit(ack, 1'b1, "wr_stop_ack");
    total++;
    if (strobe_cnt - s0 !== 2) begin
      bad++;
      $display("FAIL wr_strobe_count got=%0d exp=2", strobe_cnt - s0);
    end
    check_reg(4'd3, 8'hA5, "wr_reg");
    check_reg(4'd4, 8'h5A, "wr_reg");
  endtask

  task automatic test_ptr_continue;
    @(posedge clk); #1;
    host_addr = 4'd5; host_wdata = 8'hC3; host_we = 1'b1;
    #1;
    total++;
    if (host_rdata !== 8'h00) begin
      bad++;
      $display("FAIL host_prewrite got=%02h exp=00", host_rdata);
    end
    @(posedge clk); #1;
    host_we = 1'b0; mem[5] = 8'hC3;
    check_reg(4'd5, 8'hC3, "host_write");
    pulse(0);
    send_byte(8'h85, 1'b0, "cont_read_addr");
    check_bit(rd_req, 1'b1, "cont_rd_req");
    total++;
    if (rd_data !== 8'hC3) begin
      bad++;
      $display("FAIL cont_rd_data got=%02h exp=c3", rd_data);
    end
    pulse(1);
  endtask

  task automatic test_ignore;
    int s0;
    s0 = strobe_cnt;
    pulse(0);
    send_byte(8'h90, 1'b1, "ign_addr");
    send_byte(8'h01, 1'b1, "ign_byte");
    send_byte(8'h42, 1'b1, "ign_byte2");
    check_bit(rd_req, 1'b0, "ign_rd_req");
    pulse(1);
    total++;
    if (strobe_cnt != s0) begin
      bad++;
      $display("FAIL ign_strobe_count got=%0d exp=0", strobe_cnt - s0);
    end
  endtask

  task automatic test_read;
    pulse(0);
    send_byte(8'h84, 1'b0, "rd_wr_addr");
    send_byte(8'h03, 1'b0, "rd_ptr");
    pulse(0);
    send_byte(8'h85, 1'b0, "rd_addr");
    check_bit(rd_req, 1'b1, "rd_req_high");
    total++;
    if (rd_data !== mem[3]) begin
      bad++;
      $display("FAIL rd_data0 got=%02h exp=%02h", rd_data, mem[3]);
    end
    send_byte(8'h00, 1'b1, "rd_byte_ignored");
    pulse(2);
    total++;
    if (rd_data !== mem[4]) begin
      bad++;
      $display("FAIL rd_data1 got=%02h exp=%02h", rd_data, mem[4]);
    end
    pulse(1);
    check_bit(rd_req, 1'b0, "rd_req_after_stop");
  endtask

  task automatic test_wrap;
    pulse(0);
    send_byte(8'h84, 1'b0, "wrap_addr");
    send_byte(8'h0F, 1'b0, "wrap_ptr");
    exp_q.push_back(4'd15); mem[15] = 8'h11;
    send_byte(8'h11, 1'b0, "wrap_d0");
    exp_q.push_back(4'd0); mem[0] = 8'h22;
    send_byte(8'h22, 1'b0, "wrap_d1");
    pulse(1);
    check_reg(4'd15, 8'h11, "wrap_reg");
    check_reg(4'd0, 8'h22, "wrap_reg");
    pulse(0);
    send_byte(8'h84, 1'b0, "badptr_addr");
    send_byte(8'h10, 1'b1, "badptr_ptr");
    send_byte(8'h55, 1'b1, "badptr_data");
    pulse(1);
    check_reg(4'd1, mem[1], "badptr_reg");
  endtask

  task automatic test_host_collision;
    pulse(0);
    send_byte(8'h84, 1'b0, "col_addr");
    send_byte(8'h02, 1'b0, "col_ptr");
    exp_q.push_back(4'd2); mem[2] = 8'h33;
    send_byte_host(8'h33, 1'b0, "col_same", 1'b1, 4'd2, 8'h77);
    pulse(1);
    check_reg(4'd2, 8'h33, "col_same");
    pulse(0);
    send_byte(8'h84, 1'b0, "col2_addr");
    send_byte(8'h02, 1'b0, "col2_ptr");
    exp_q.push_back(4'd2); mem[5] = 8'h77;
    send_byte_host(8'h33, 1'b0, "col_diff", 1'b1, 4'd5, 8'h77);
    pulse(1);
    check_reg(4'd2, 8'h33, "col_diff");
    check_reg(4'd5, 8'h77, "col_diff");
  endtask

  task automatic test_reset_mid;
    int s0;
    logic allz;
    pulse(0);
    send_byte(8'h84, 1'b0, "rst_addr");
    send_byte(8'h00, 1'b0, "rst_ptr");
    s0 = strobe_cnt;
    @(posedge clk); #1;
    rx_data = 8'h66; data_rdy = 1'b0;
    #2 rstn = 1'b0;
    #1;
    check_bit(ack, 1'b1, "rst_mid_ack");
    allz = 1'b1;
    for (int i = 0; i < 16; i++) begin
      host_addr = i[3:0];
      #1;
      if (host_rdata !== 8'h00) allz = 1'b0;
    end
    check_bit(allz, 1'b1, "rst_mid_regs_zero");
    @(posedge clk); #1 rstn = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_bit(ack, 1'b1, "rst_release_ack");
    data_rdy = 1'b1;
    repeat (2) @(posedge clk);
    total++;
    if (strobe_cnt != s0) begin
      bad++;
      $display("FAIL rst_release_strobe got=%0d exp=0", strobe_cnt - s0);
    end
    check_reg(4'd0, 8'h00, "rst_release_reg");
  endtask

  initial begin
    test_reset();
    test_write();
    test_ptr_continue();
    test_ignore();
    test_read();
    test_wrap();
    test_host_collision();
    test_reset_mid();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_strobes got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
